// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit (byte/half/word) with req/ack data-memory handshake.
// Define MEM_LSU_ALIGN_CHECK_EN to raise AdEL/AdES on misaligned half/word accesses.
module mem_lsu #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [3:0]          mem_op,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   store_i,
  input  logic [DATA_W-1:0]   alu_i,
  input  logic [4:0]          wd_i,
  input  logic                wreg_i,
  input  logic                flush,
  output logic                stall_o,
  output logic                dm_req,
  output logic                dm_we,
  output logic [DATA_W/8-1:0] dm_be,
  output logic [ADDR_W-1:0]   dm_addr,
  output logic [DATA_W-1:0]   dm_wdata,
  input  logic                dm_ack,
  input  logic [DATA_W-1:0]   dm_rdata,
  output logic                out_valid,
  output logic [4:0]          wd_o,
  output logic                wreg_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [4:0]          exc_o,
  output logic [ADDR_W-1:0]   badvaddr_o
);
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned LANE_W = $clog2(BE_W);
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4, OP_LW = 4'd5;
  localparam logic [3:0] OP_SB = 4'd8, OP_SH = 4'd9, OP_SW = 4'd10;
  localparam logic [4:0] EXC_NONE = 5'd0, EXC_ADEL = 5'd4, EXC_ADES = 5'd5, EXC_DBE = 5'd7;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
  state_t state, state_nx;

  logic [CNT_W-1:0]  cnt;
  logic [3:0]        op_q;
  logic [LANE_W-1:0] lane_q;
  logic [4:0]        wd_q;
  logic              wreg_q, flushed_q;
  logic [ADDR_W-1:0] addr_q;

  logic              is_load, is_store, is_mem, sz_half, sz_word, misaligned;
  logic              accept, mem_go, busy_ack, busy_to;
  logic [LANE_W-1:0] lane_in;
  logic [BE_W-1:0]   be_in;
  logic [DATA_W-1:0] bus_in, shifted, load_data;

  // Decode of the presented op, lane/byte-enable generation and load extraction
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sz_half  = 1'b0;
    sz_word  = 1'b0;
    case (mem_op)
      OP_LB, OP_LBU: is_load = 1'b1;
      OP_LH, OP_LHU: begin is_load = 1'b1; sz_half = 1'b1; end
      OP_LW:         begin is_load = 1'b1; sz_word = 1'b1; end
      OP_SB:         is_store = 1'b1;
      OP_SH:         begin is_store = 1'b1; sz_half = 1'b1; end
      OP_SW:         begin is_store = 1'b1; sz_word = 1'b1; end
      default:       ;
    endcase
    is_mem = is_load | is_store;
`ifdef MEM_LSU_ALIGN_CHECK_EN
    misaligned = (sz_half & addr_i[0]) | (sz_word & (addr_i[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
    // Without the alignment check the access is forced to natural alignment
    lane_in = addr_i[LANE_W-1:0];
    if (sz_half) lane_in[0] = 1'b0;
    if (sz_word) lane_in[1:0] = 2'b00;

    if (sz_word) begin
      be_in  = BE_W'(4'hF) << lane_in;
      bus_in = {(DATA_W/32){store_i[31:0]}};
    end else if (sz_half) begin
      be_in  = BE_W'(2'b11) << lane_in;
      bus_in = {(DATA_W/16){store_i[15:0]}};
    end else begin
      be_in  = BE_W'(1'b1) << lane_in;
      bus_in = {(DATA_W/8){store_i[7:0]}};
    end

    accept   = ((state == IDLE) || (state == RESP)) && in_valid && !flush;
    mem_go   = accept & is_mem & ~misaligned;
    busy_ack = (state == BUSY) & dm_ack;
    busy_to  = (state == BUSY) & ~dm_ack & (cnt == CNT_LAST);

    shifted = dm_rdata >> {lane_q, 3'b000};
    case (op_q)
      OP_LB:   load_data = DATA_W'($signed(shifted[7:0]));
      OP_LBU:  load_data = DATA_W'(shifted[7:0]);
      OP_LH:   load_data = DATA_W'($signed(shifted[15:0]));
      OP_LHU:  load_data = DATA_W'(shifted[15:0]);
      OP_LW:   load_data = DATA_W'($signed(shifted[31:0]));
      default: load_data = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, RESP: state_nx = mem_go ? BUSY : IDLE;
      BUSY:       if (busy_ack || busy_to) state_nx = RESP;
      default:    state_nx = IDLE;
    endcase
  end

  // Stall covers the accept cycle of a memory op and every BUSY cycle
  always_comb begin
    stall_o = mem_go | (state == BUSY);
  end

  // Bus request, captured instruction and MEM/WB result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      op_q       <= '0;
      lane_q     <= '0;
      wd_q       <= '0;
      wreg_q     <= 1'b0;
      flushed_q  <= 1'b0;
      addr_q     <= '0;
      dm_req     <= 1'b0;
      dm_we      <= 1'b0;
      dm_be      <= '0;
      dm_addr    <= '0;
      dm_wdata   <= '0;
      out_valid  <= 1'b0;
      wd_o       <= '0;
      wreg_o     <= 1'b0;
      wdata_o    <= '0;
      exc_o      <= EXC_NONE;
      badvaddr_o <= '0;
    end else begin
      out_valid <= 1'b0;
      if (state == BUSY) begin
        cnt <= cnt + CNT_W'(1);
        if (flush) flushed_q <= 1'b1;
        if (busy_ack || busy_to) begin
          cnt        <= '0;
          dm_req     <= 1'b0;
          dm_we      <= 1'b0;
          dm_be      <= '0;
          dm_addr    <= '0;
          dm_wdata   <= '0;
          out_valid  <= ~(flushed_q | flush);
          wd_o       <= wd_q;
          wreg_o     <= wreg_q & busy_ack & ~(flushed_q | flush);
          wdata_o    <= busy_ack ? load_data : '0;
          exc_o      <= busy_ack ? EXC_NONE : EXC_DBE;
          badvaddr_o <= busy_ack ? '0 : addr_q;
        end
      end
      if (accept) begin
        cnt       <= '0;
        flushed_q <= 1'b0;
        op_q      <= mem_op;
        lane_q    <= lane_in;
        wd_q      <= wd_i;
        wreg_q    <= wreg_i;
        addr_q    <= addr_i;
        if (mem_go) begin
          dm_req   <= 1'b1;
          dm_we    <= is_store;
          dm_be    <= be_in;
          dm_addr  <= {addr_i[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
          dm_wdata <= bus_in;
        end else begin
          out_valid <= 1'b1;
          wd_o      <= wd_i;
          if (is_mem) begin
            wreg_o     <= 1'b0;
            wdata_o    <= '0;
            exc_o      <= is_load ? EXC_ADEL : EXC_ADES;
            badvaddr_o <= addr_i;
          end else begin
            wreg_o     <= wreg_i;
            wdata_o    <= alu_i;
            exc_o      <= EXC_NONE;
            badvaddr_o <= '0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed vector table, randomized ops against a
// byte-level reference model, and hand sequences for timeout, flush and reset.
module tb_mem_lsu;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst, in_valid, wreg_i, flush, dm_ack;
  logic [3:0]    mem_op;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] store_i, alu_i, dm_rdata;
  logic [4:0]    wd_i;
  logic          stall_o, dm_req, dm_we, out_valid, wreg_o;
  logic [3:0]    dm_be;
  logic [AW-1:0] dm_addr, badvaddr_o;
  logic [DW-1:0] dm_wdata, wdata_o;
  logic [4:0]    wd_o, exc_o;

  always #5 clk = ~clk;

  mem_lsu #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mem_op(mem_op), .addr_i(addr_i),
    .store_i(store_i), .alu_i(alu_i), .wd_i(wd_i), .wreg_i(wreg_i), .flush(flush),
    .stall_o(stall_o), .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .out_valid(out_valid),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .exc_o(exc_o), .badvaddr_o(badvaddr_o)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr, store, alu, rdata;
    logic [4:0]  wd;
    logic        wreg;
    int          k;      // ack delay in cycles after accept; 0 = never ack
    logic        mem;    // a bus request is expected
    logic        we;
    logic [3:0]  be;
    logic [31:0] daddr, bus, wdo;
    logic [4:0]  exc;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [3:0] op, input logic [31:0] addr, store, alu, rdata,
                     input logic [4:0] wd, input logic wreg, input int k, input logic mem, we,
                     input logic [3:0] be, input logic [31:0] daddr, bus, wdo, input logic [4:0] exc);
    vec_t v;
    v.op = op; v.addr = addr; v.store = store; v.alu = alu; v.rdata = rdata;
    v.wd = wd; v.wreg = wreg; v.k = k; v.mem = mem; v.we = we; v.be = be;
    v.daddr = daddr; v.bus = bus; v.wdo = wdo; v.exc = exc;
    vecs.push_back(v);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " dm_req"}, dm_req, 0);
    check({tag, " dm_we"}, dm_we, 0);
    check({tag, " dm_be"}, dm_be, 0);
    check({tag, " dm_addr"}, dm_addr, 0);
    check({tag, " dm_wdata"}, dm_wdata, 0);
    check({tag, " out_valid"}, out_valid, 0);
    check({tag, " wd_o"}, wd_o, 0);
    check({tag, " wreg_o"}, wreg_o, 0);
    check({tag, " wdata_o"}, wdata_o, 0);
    check({tag, " exc_o"}, exc_o, 0);
    check({tag, " badvaddr_o"}, badvaddr_o, 0);
    check({tag, " stall_o"}, stall_o, 0);
  endtask

  // Present one instruction, service the bus with the given ack delay, check the result
  task automatic run_txn(input vec_t v, input string tag);
    int lim;
    in_valid = 1'b1; mem_op = v.op; addr_i = v.addr; store_i = v.store; alu_i = v.alu;
    wd_i = v.wd; wreg_i = v.wreg; flush = 1'b0; dm_ack = 1'b0;
    #1;
    check({tag, " stall_accept"}, stall_o, v.mem);
    next_cycle();
    in_valid = 1'b0; mem_op = 4'd0;
    if (v.mem) begin
      lim = (v.k == 0) ? int'(TO) : v.k;
      for (int c = 1; c <= lim; c++) begin
        #1;
        check({tag, " busy dm_req"}, dm_req, 1);
        check({tag, " busy stall"}, stall_o, 1);
        if (c == 1) begin
          check({tag, " dm_be"}, dm_be, v.be);
          check({tag, " dm_addr"}, dm_addr, v.daddr);
          check({tag, " dm_we"}, dm_we, v.we);
          if (v.we) check({tag, " dm_wdata"}, dm_wdata, v.bus);
        end
        if (c == v.k) begin dm_ack = 1'b1; dm_rdata = v.rdata; end
        next_cycle();
        dm_ack = 1'b0; dm_rdata = $urandom;
      end
    end
    #1;
    check({tag, " out_valid"}, out_valid, 1);
    check({tag, " exc_o"}, exc_o, v.exc);
    check({tag, " wd_o"}, wd_o, v.wd);
    check({tag, " wreg_o"}, wreg_o, (v.exc != 0) ? 1'b0 : v.wreg);
    check({tag, " badvaddr_o"}, badvaddr_o, (v.exc != 0) ? v.addr : 32'd0);
    if (v.exc == 0) check({tag, " wdata_o"}, wdata_o, v.wdo);
    check({tag, " resp dm_req"}, dm_req, 0);
    check({tag, " resp stall"}, stall_o, 0);
    next_cycle();
    check({tag, " out_valid drop"}, out_valid, 0);
  endtask

  function automatic int op_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd8: return 1;
      4'd3, 4'd4, 4'd9: return 2;
      4'd5, 4'd10:      return 4;
      default:          return 0;
    endcase
  endfunction

  function automatic bit op_load(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd5);
  endfunction

  function automatic bit op_signed(input logic [3:0] op);
    return (op == 4'd1) || (op == 4'd3) || (op == 4'd5);
  endfunction

  // Reference: byte-addressed view of the access, built from sizes and masks
  function automatic vec_t model(input vec_t v);
    vec_t        r;
    int          sz, lane;
    bit          mis;
    logic [31:0] ea;
    logic [63:0] mask, val;
    r = v;
    sz = op_size(v.op);
    mis = 1'b0;
    r.mem = 1'b0; r.we = 1'b0; r.be = 4'd0; r.daddr = 32'd0; r.bus = 32'd0;
    r.exc = 5'd0; r.wdo = v.alu;
    if (sz != 0) begin
      r.wdo = 32'd0;
`ifdef MEM_LSU_ALIGN_CHECK_EN
      mis = (v.addr % sz) != 0;
`endif
      if (mis) begin
        r.exc = op_load(v.op) ? 5'd4 : 5'd5;
      end else begin
        ea = v.addr - (v.addr % sz);
        lane = int'(ea % 4);
        r.mem = 1'b1;
        r.we = !op_load(v.op);
        r.daddr = ea - 32'(lane);
        r.be = 4'(((1 << sz) - 1) << lane);
        for (int b = 0; b < 4; b++) r.bus[8*b +: 8] = v.store[8*(b % sz) +: 8];
        if (op_load(v.op)) begin
          mask = (64'd1 << (8*sz)) - 64'd1;
          val = ({32'd0, v.rdata} >> (8*lane)) & mask;
          if (op_signed(v.op) && val[8*sz-1]) val = val | ~mask;
          r.wdo = val[31:0];
        end
      end
    end
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ops [10];
    vec_t       v;
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd12};

    //  op     addr          store         alu           rdata         wd  wr k  mem we be       daddr         bus           wdo           exc
    add(4'd1,  32'h0000_1003, 32'h0,        32'h0,        32'h8000_0000, 5'd3, 1, 2, 1, 0, 4'b1000, 32'h0000_1000, 32'h0,        32'hFFFF_FF80, 5'd0);
    add(4'd9,  32'h0000_2002, 32'h1234_ABCD, 32'h0,        32'h0,        5'd0, 0, 1, 1, 1, 4'b1100, 32'h0000_2000, 32'hABCD_ABCD, 32'h0,        5'd0);
`ifdef MEM_LSU_ALIGN_CHECK_EN
    add(4'd5,  32'h0000_3001, 32'h0,        32'h0,        32'h89AB_CDEF, 5'd4, 1, 1, 0, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        5'd4);
    add(4'd9,  32'h0000_2003, 32'h0000_1234, 32'h0,        32'h0,        5'd0, 0, 1, 0, 0, 4'b0000, 32'h0,        32'h0,        32'h0,        5'd5);
`else
    add(4'd5,  32'h0000_3001, 32'h0,        32'h0,        32'h89AB_CDEF, 5'd4, 1, 1, 1, 0, 4'b1111, 32'h0000_3000, 32'h0,        32'h89AB_CDEF, 5'd0);
    add(4'd9,  32'h0000_2003, 32'h0000_1234, 32'h0,        32'h0,        5'd0, 0, 1, 1, 1, 4'b1100, 32'h0000_2000, 32'h1234_1234, 32'h0,        5'd0);
`endif
    add(4'd4,  32'h0000_4000, 32'h0,        32'h0,        32'h0,        5'd6, 1, 0, 1, 0, 4'b0011, 32'h0000_4000, 32'h0,        32'h0,        5'd7);
    add(4'd0,  32'h0000_0000, 32'h0,        32'hDEAD_BEEF, 32'h0,        5'd7, 1, 1, 0, 0, 4'b0000, 32'h0,        32'h0,        32'hDEAD_BEEF, 5'd0);
    add(4'd6,  32'h0000_0013, 32'h0,        32'h00C0_FFEE, 32'h0,        5'd31, 1, 1, 0, 0, 4'b0000, 32'h0,       32'h0,        32'h00C0_FFEE, 5'd0);
    add(4'd2,  32'h0000_1001, 32'h0,        32'h0,        32'h0000_F000, 5'd8, 1, 3, 1, 0, 4'b0010, 32'h0000_1000, 32'h0,        32'h0000_00F0, 5'd0);
    add(4'd3,  32'h0000_0010, 32'h0,        32'h0,        32'h0000_8001, 5'd9, 1, 1, 1, 0, 4'b0011, 32'h0000_0010, 32'h0,        32'hFFFF_8001, 5'd0);
    add(4'd4,  32'h0000_0012, 32'h0,        32'h0,        32'h8001_0000, 5'd10, 1, 2, 1, 0, 4'b1100, 32'h0000_0010, 32'h0,       32'h0000_8001, 5'd0);
    add(4'd8,  32'h0000_0005, 32'h0000_0055, 32'h0,        32'h0,        5'd0, 0, 1, 1, 1, 4'b0010, 32'h0000_0004, 32'h5555_5555, 32'h0,        5'd0);
    add(4'd10, 32'h0000_0008, 32'hCAFE_F00D, 32'h0,        32'h0,        5'd0, 0, 4, 1, 1, 4'b1111, 32'h0000_0008, 32'hCAFE_F00D, 32'h0,        5'd0);
    add(4'd1,  32'h0000_0007, 32'h0,        32'h0,        32'h7F00_0000, 5'd11, 1, 1, 1, 0, 4'b1000, 32'h0000_0004, 32'h0,       32'h0000_007F, 5'd0);

    rst = 1'b1; in_valid = 1'b0; mem_op = 4'd0; addr_i = '0; store_i = '0; alu_i = '0;
    wd_i = '0; wreg_i = 1'b0; flush = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    next_cycle();

    foreach (vecs[i]) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Flush during BUSY: response suppressed, then a non-memory op accepted in RESP
    in_valid = 1'b1; mem_op = 4'd5; addr_i = 32'h100; wd_i = 5'd12; wreg_i = 1'b1;
    next_cycle();
    in_valid = 1'b0; flush = 1'b1;
    #1;
    check("flush busy dm_req", dm_req, 1);
    next_cycle();
    flush = 1'b0;
    next_cycle();
    dm_ack = 1'b1; dm_rdata = 32'h1111_2222;
    next_cycle();
    dm_ack = 1'b0;
    check("flush resp out_valid", out_valid, 0);
    check("flush resp dm_req", dm_req, 0);
    in_valid = 1'b1; mem_op = 4'd0; alu_i = 32'h1357_2468; wd_i = 5'd9; wreg_i = 1'b1;
    #1;
    check("b2b accept stall", stall_o, 0);
    next_cycle();
    in_valid = 1'b0;
    check("b2b out_valid", out_valid, 1);
    check("b2b wdata_o", wdata_o, 32'h1357_2468);
    check("b2b wd_o", wd_o, 5'd9);
    check("b2b wreg_o", wreg_o, 1);
    next_cycle();

    // Flush in IDLE with a stray ack: nothing accepted
    in_valid = 1'b1; mem_op = 4'd5; addr_i = 32'h200; flush = 1'b1; dm_ack = 1'b1;
    #1;
    check("idle flush stall", stall_o, 0);
    next_cycle();
    in_valid = 1'b0; flush = 1'b0; dm_ack = 1'b0;
    check("idle flush out_valid", out_valid, 0);
    check("idle flush dm_req", dm_req, 0);
    next_cycle();

    // Reset while BUSY
    in_valid = 1'b1; mem_op = 4'd10; addr_i = 32'h20; store_i = 32'hA5A5_5A5A; wreg_i = 1'b0;
    next_cycle();
    in_valid = 1'b0;
    check("rst busy dm_req", dm_req, 1);
    rst = 1'b1;
    next_cycle();
    check_all_zero("rst busy");
    rst = 1'b0;
    next_cycle();

    // Randomized ops against the reference model
    for (int n = 0; n < 40; n++) begin
      v.op = ops[$urandom_range(0, 9)];
      v.addr = $urandom; v.store = $urandom; v.alu = $urandom; v.rdata = $urandom;
      v.wd = 5'($urandom); v.wreg = 1'($urandom); v.k = int'($urandom_range(1, 4));
      run_txn(model(v), $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Parametrised load/store unit for the MEM pipeline stage. It replaces the word-only, single-cycle memory access path with byte, halfword and word loads and stores. Each access uses a req/ack data-memory handshake with a stall output, a bus-timeout error and address-alignment exceptions. It sits between the EX/MEM pipeline register and MEM/WB, and drives the data-memory port directly.

## Interface
Parameters:
- DATA_W, 32, datapath width; legal values are 32 or 64. Word loads sign-extend to DATA_W.
- ADDR_W, 32, data-memory address width.
- TIMEOUT, 16, maximum number of req cycles without ack before a bus error is raised; range 2..255.

Ports (the clock is `clk`; the reset is `rst`, synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  EX/MEM presents an instruction this cycle
- mem_op  in  4  0=none, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW, 8=SB, 9=SH, 10=SW; other values are treated as none
- addr_i  in  ADDR_W  effective address
- store_i  in  DATA_W  store data (rt), right-aligned
- alu_i  in  DATA_W  EX result, forwarded for non-memory ops
- wd_i  in  5  destination register
- wreg_i  in  1  register-write enable
- flush  in  1  discard the current or in-flight instruction
- stall_o  out  1  the pipeline must hold EX/MEM
- dm_req  out  1  memory request
- dm_we  out  1  write request
- dm_be  out  DATA_W/8  byte enables
- dm_addr  out  ADDR_W  address aligned down to DATA_W/8
- dm_wdata  out  DATA_W  lane-replicated store data
- dm_ack  in  1  request completed this cycle
- dm_rdata  in  DATA_W  read data, valid when dm_ack=1
- out_valid  out  1  result valid to MEM/WB
- wd_o  out  5  destination register
- wreg_o  out  1  write enable, forced to 0 when an exception is raised
- wdata_o  out  DATA_W  load data or alu_i
- exc_o  out  5  0=none, 4=AdEL, 5=AdES, 7=DBE
- badvaddr_o  out  ADDR_W  faulting address; 0 when exc_o=0

## Operation
- FSM states: IDLE, BUSY, RESP.
- Accept condition: in IDLE with in_valid=1 and flush=0, the block captures all inputs.
- Non-memory op: stays in IDLE; at the next cycle out_valid=1, wdata_o=alu_i and wd_o/wreg_o are passed through.
- Memory op, aligned: transition to BUSY. stall_o=1 combinationally on the accept cycle.
- Memory op, misaligned (only with alignment checking enabled): no request is issued. The next cycle gives out_valid=1 with exc_o=4 (load) or 5 (store), badvaddr_o=addr_i and wreg_o=0.
- BUSY: dm_req=1, and dm_addr/dm_be/dm_we/dm_wdata are held constant.
  - dm_ack=1: go to RESP.
  - The timeout counter increments on every BUSY cycle without ack. When it reaches TIMEOUT-1 with no ack, the block drops the request, goes to RESP and sets exc_o=7.
- RESP: out_valid=1 for exactly one cycle, stall_o=0, then return to IDLE. A new instruction can be accepted in this same cycle.
- Byte lanes are little-endian and indexed by lane = addr_i[log2(DATA_W/8)-1:0].
  - Byte ops: dm_be has one bit set at the lane.
  - Halfword ops: two adjacent bits.
  - Word ops: four bits.
  - dm_wdata replicates the byte, halfword or word across the full bus.
- Load extraction: shift dm_rdata right by lane*8. LB/LH/LW sign-extend to DATA_W; LBU/LHU zero-extend.
- Stores: wdata_o=0. Writeback is governed by wreg_i, which the decoder clears for stores.
- Flush in IDLE: nothing is accepted and out_valid=0 next cycle.
- Flush in BUSY: the bus transaction still completes (ack or timeout), but RESP outputs out_valid=0. A latched flag tracks this.
- flush has no effect in RESP.

## Timing
- Reset: state=IDLE, counter=0. All outputs are 0: dm_req, dm_we, dm_be, dm_addr, dm_wdata, out_valid, wd_o, wreg_o, wdata_o, exc_o, badvaddr_o and stall_o.
- Reset mid-transaction drops dm_req the next cycle. The memory must tolerate an abandoned request.
- Latency from accept (cycle N):
  - Non-memory op or exception: out_valid at N+1.
  - Memory op with ack at N+k (k≥1): out_valid at N+k+1.
- stall_o is high from N through N+k inclusive.
- dm_ack is ignored outside BUSY.
- Timeout bus error: out_valid at N+TIMEOUT+1.

## Configuration
- MEM_LSU_ALIGN_CHECK_EN defined: halfword ops with addr[0]≠0 and word ops with addr[1:0]≠0 raise AdEL/AdES as described above.
- Not defined: no alignment check, exc_o never takes 4 or 5, and the offending low address bits are cleared before lane selection, so the access is forced to natural alignment.

## Test plan
- LB at addr 0x1003 with dm_rdata=0x80_00_00_00 and ack after 2 cycles: dm_be=4'b1000; wdata_o=0xFFFFFF80 at N+3; stall_o high for N..N+2.
- SH of 0x1234ABCD at addr 0x2002 with immediate ack: dm_be=4'b1100, dm_wdata=0xABCDABCD, dm_we=1; out_valid at N+2 with wreg_o=0.
- LW at addr 0x3001 with MEM_LSU_ALIGN_CHECK_EN defined: no dm_req; exc_o=4, badvaddr_o=0x3001 at N+1. Without the macro: dm_addr=0x3000 and a normal load.
- LHU at 0x4000 with ack never asserted and TIMEOUT=16: dm_req drops after 16 cycles; exc_o=7, wreg_o=0, out_valid at N+17.
- Flush asserted at N+1 while BUSY, ack at N+3: out_valid stays 0. A back-to-back non-memory op accepted at N+4 gives out_valid=1 with wdata_o=alu_i at N+5.
- rst asserted during BUSY: dm_req=0 and all outputs are 0 on the following cycle.
